// File: rtl/bram_dma.sv
// Block fill / ascending block copy engine driving one single-port BRAM word interface.
// Outputs decode directly from the state register, so an asynchronous reset silences the port at once.
module bram_dma #(
    parameter int DP = 512,
    parameter int DW = 32,
    parameter int MW = DW/8,
    parameter int AW = $clog2(DP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] fill_data,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [MW-1:0] mem_sel,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rvalid
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [DW-1:0] data_q, data_d;
    logic          abt_q, abt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            fill_q  <= '0;
            data_q  <= '0;
            abt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            abt_q   <= abt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        fill_d    = fill_q;
        data_d    = data_q;
        abt_d     = abt_q;
        busy      = 1'b0;
        done      = 1'b0;
        aborted   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_sel   = '0;
        mem_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d  = src;
                    dst_d  = dst;
                    cnt_d  = len;
                    mode_d = mode;
                    fill_d = fill_data;
                    abt_d  = 1'b0;
                    if (len == '0)
                        state_d = DONE;
                    else if (mode)
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                busy     = 1'b1;
                mem_addr = src_q;
                if (abort) begin
                    abt_d   = 1'b1;
                    state_d = DONE;
                end else if (mem_rvalid) begin
                    data_d  = mem_rdata;
                    state_d = WR;
                end
            end
            WR: begin
                busy      = 1'b1;
                mem_addr  = dst_q;
                mem_wdata = mode_q ? fill_q : data_q;
                mem_sel   = '1;
                mem_we    = 1'b1;
                dst_d     = dst_q + AW'(1);
                if (!mode_q)
                    src_d = src_q + AW'(1);
                cnt_d     = cnt_q - (AW+1)'(1);
                // The write issued this cycle lands even when aborting.
                if (abort) begin
                    abt_d   = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == (AW+1)'(1))
                    state_d = DONE;
                else
                    state_d = mode_q ? WR : RD;
            end
            DONE: begin
                done    = 1'b1;
                aborted = abt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bram_dma.sv
// Bench for bram_dma: BRAM array model, directed and random transfers scored against
// a word-by-word memory reference and the expected write/done cycle schedule.
module tb_bram_dma;
    localparam int DP = 512;
    localparam int DW = 32;
    localparam int MW = DW/8;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src = '0;
    logic [AW-1:0] dst = '0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] fill_data = '0;
    logic          abort = 1'b0;
    logic          mem_rvalid = 1'b1;
    logic          busy, done, aborted, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [MW-1:0] mem_sel;

    logic [DW-1:0] mem  [DP];
    logic [DW-1:0] refm [DP];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    bram_dma #(.DP(DP), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
        .len(len), .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
        .aborted(aborted), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer: launch, track every cycle, then compare against the reference memory.
    task automatic run(input string tag, input logic m, input int s, input int d, input int n,
                       input logic [DW-1:0] f, input int stall, input int abort_cyc,
                       input bit busy_start);
        int cyc, writes, nw, exp_done, mism, stall_left;
        bit got;
        for (int i = 0; i < DP; i++) refm[i] = mem[i];
        nw = n;
        if (abort_cyc > 0) begin
            nw = 0;
            for (int k = 1; k <= n; k++)
                if ((m ? k : 2*k + stall) <= abort_cyc) nw++;
        end
        for (int k = 0; k < nw; k++)
            refm[(d + k) % DP] = m ? f : refm[(s + k) % DP];
        if (abort_cyc > 0)      exp_done = abort_cyc + 1;
        else if (n == 0)        exp_done = 1;
        else if (m)             exp_done = n + 1;
        else                    exp_done = 2*n + 1 + stall;

        @(negedge clk);
        mode = m; src = AW'(s); dst = AW'(d); len = (AW+1)'(n); fill_data = f;
        start = 1'b1; mem_rvalid = 1'b1; stall_left = stall;
        @(posedge clk);
        #1;
        start = 1'b0; mode = ~m; src = ~src; dst = ~dst; len = (AW+1)'(7); fill_data = ~f;

        cyc = 0; writes = 0; got = 0;
        while (!got && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            abort = (cyc == abort_cyc);
            start = busy_start && (cyc == 2 || done);
            if (busy && !mem_we) begin
                mem_rvalid = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end else
                mem_rvalid = 1'b1;
            if (mem_we) begin
                writes++;
                check({tag, "_waddr"}, 64'(mem_addr), 64'((d + writes - 1) % DP));
                check({tag, "_wcycle"}, 64'(cyc), 64'(m ? writes : 2*writes + stall));
                check({tag, "_wsel"}, 64'(mem_sel), 64'({MW{1'b1}}));
            end
            if (done) got = 1;
        end
        abort = 1'b0;
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_done));
        check({tag, "_aborted"}, 64'(aborted), 64'(abort_cyc > 0));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_writes"}, 64'(writes), 64'(nw));
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_pulse"}, 64'({done, busy, mem_we}), 64'd0);
        mism = 0;
        for (int i = 0; i < DP; i++) if (mem[i] !== refm[i]) mism++;
        check({tag, "_mem"}, 64'(mism), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] keep;
        for (int i = 0; i < DP; i++) mem[i] = $urandom;
        #2;
        check("reset_outputs", {busy, done, aborted, mem_we, mem_sel, mem_addr, mem_wdata}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("fill_basic", 1'b1, 0, 8, 4, 32'hA5A5A5A5, 0, 0, 1'b0);
        mem[16] = 32'd1; mem[17] = 32'd2; mem[18] = 32'd3;
        run("copy_basic", 1'b0, 16, 32, 3, 32'h0, 0, 0, 1'b0);
        check("copy_word0", 64'(mem[32]), 64'd1);
        check("copy_word2", 64'(mem[34]), 64'd3);
        run("fill_wrap", 1'b1, 0, 510, 4, 32'h0BADF00D, 0, 0, 1'b0);
        run("copy_wrap", 1'b0, 509, 100, 5, 32'h0, 0, 0, 1'b0);
        run("len_zero_fill", 1'b1, 0, 20, 0, 32'h12345678, 0, 0, 1'b0);
        run("len_zero_copy", 1'b0, 5, 20, 0, 32'h0, 0, 0, 1'b0);
        run("stall", 1'b0, 40, 200, 2, 32'h0, 3, 0, 1'b0);
        run("abort_wr", 1'b0, 60, 300, 8, 32'h0, 0, 4, 1'b0);
        run("abort_rd", 1'b0, 70, 310, 8, 32'h0, 0, 5, 1'b0);
        run("abort_fill", 1'b1, 0, 320, 10, 32'hCAFEBABE, 0, 3, 1'b0);
        run("overlap", 1'b0, 50, 52, 6, 32'h0, 0, 0, 1'b0);
        run("start_busy", 1'b0, 64, 96, 5, 32'h0, 0, 0, 1'b1);
        run("fill_full", 1'b1, 0, 300, DP, 32'h5A5A5A5A, 0, 0, 1'b0);
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < DP; i++) mem[i] = $urandom;
            run($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), int'($urandom_range(0, DP-1)),
                int'($urandom_range(0, DP-1)), int'($urandom_range(0, 48)), $urandom,
                int'($urandom_range(0, 2)), 0, 1'b0);
        end

        // Asynchronous reset in the middle of a fill.
        keep = mem[102];
        @(negedge clk);
        mode = 1'b1; dst = AW'(100); len = (AW+1)'(8); fill_data = 32'hDEADBEEF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_we", 64'(mem_we), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_outputs", {busy, done, aborted, mem_we, mem_sel, mem_addr, mem_wdata}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_quiet", 64'({done, mem_we, busy}), 64'd0);
        end
        check("rst_word101", 64'(mem[101]), 64'hDEADBEEF);
        check("rst_word102", 64'(mem[102]), 64'(keep));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_idle", 64'({done, mem_we, busy}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
